// File: rtl/rv32i_program_writer.sv
// Encodes RV32I instructions from op/register/immediate fields and writes them sequentially into instruction RAM.
// Two cycles per instruction (accept, then write); illegal commands latch a sticky error until clear/rst.
module rv32i_program_writer #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, WRITE, FULL, ERR} state_t;

  localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wptr;
  logic [31:0]       enc;
  logic              legal;
  logic [2:0]        f3;
  logic              fits12;
  logic              accept;

  always_comb begin
    f3 = 3'd0;
    case (in_op)
      6'd2,  6'd11:               f3 = 3'd4;
      6'd3,  6'd12:               f3 = 3'd6;
      6'd4,  6'd13:               f3 = 3'd7;
      6'd5,  6'd14:               f3 = 3'd1;
      6'd6,  6'd7, 6'd15, 6'd16:  f3 = 3'd5;
      6'd8,  6'd17:               f3 = 3'd2;
      6'd9,  6'd18:               f3 = 3'd3;
      6'd20, 6'd22:               f3 = 3'd2;
      6'd24:                      f3 = 3'd1;
      6'd25:                      f3 = 3'd4;
      6'd26:                      f3 = 3'd5;
      6'd27:                      f3 = 3'd6;
      6'd28:                      f3 = 3'd7;
      default:                    f3 = 3'd0;
    endcase
  end

  assign fits12 = ($signed(in_imm) >= -32'sd2048) && ($signed(in_imm) <= 32'sd2047);

  always_comb begin
    enc   = 32'd0;
    legal = 1'b1;
    if (in_op <= 6'd9) begin
      enc = {((in_op == 6'd1) || (in_op == 6'd7)) ? 7'h20 : 7'h00,
             in_rs2, in_rs1, f3, in_rd, 7'h33};
    end else if (in_op >= 6'd14 && in_op <= 6'd16) begin
      enc   = {(in_op == 6'd16) ? 7'h20 : 7'h00, in_imm[4:0], in_rs1, f3, in_rd, 7'h13};
      legal = (in_imm <= 32'd31);
    end else if (in_op <= 6'd18) begin
      enc   = {in_imm[11:0], in_rs1, f3, in_rd, 7'h13};
      legal = fits12;
    end else if (in_op <= 6'd20) begin
      enc   = {in_imm[11:0], in_rs1, f3, in_rd, 7'h03};
      legal = fits12;
    end else if (in_op <= 6'd22) begin
      enc   = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], 7'h23};
      legal = fits12;
    end else if (in_op <= 6'd28) begin
      enc   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1], in_imm[11], 7'h63};
      legal = ($signed(in_imm) >= -32'sd4096) && ($signed(in_imm) <= 32'sd4094) && !in_imm[0];
    end else if (in_op == 6'd29) begin
      enc   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'h6F};
      legal = ($signed(in_imm) >= -32'sd1048576) && ($signed(in_imm) <= 32'sd1048574) && !in_imm[0];
    end else if (in_op == 6'd30) begin
      enc   = {in_imm[11:0], in_rs1, 3'd0, in_rd, 7'h67};
      legal = fits12;
    end else if (in_op <= 6'd32) begin
      enc   = {in_imm[31:12], in_rd, (in_op == 6'd31) ? 7'h37 : 7'h17};
      legal = (in_imm[11:0] == 12'd0);
    end else begin
      legal = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = legal ? WRITE : ERR;
      end
      WRITE:   state_nxt = (count == CNT_LAST) ? FULL : IDLE;
      default: state_nxt = state;
    endcase
  end

  assign accept = in_valid && in_ready;
  // A reset or clear landing in the write cycle suppresses the strobe.
  assign mem_we = (state == WRITE) && !rst && !clear;
  assign full   = (count == CNT_FULL);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state     <= IDLE;
      wptr      <= '0;
      count     <= '0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && legal) begin
        mem_addr  <= wptr;
        mem_wdata <= enc;
      end
      if (accept && !legal) err <= 1'b1;
      if (state == WRITE) begin
        wptr  <= wptr + PTR_ONE;
        count <= count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_program_writer.sv
// Scoreboard bench for rv32i_program_writer at DEPTH=4: expected writes are queued on issue, checked on mem_we.
module tb_rv32i_program_writer;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst, clear, in_valid, in_ready;
  logic [5:0]    in_op;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [31:0]   in_imm;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
  logic          full, err;

  rv32i_program_writer #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [AW-1:0] exp_ptr = '0;

  // Every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: addr=%0d data=%h, required no write", mem_addr, mem_wdata);
      end else begin
        mon_e = sb.pop_front();
        if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.data) begin
          n_bad++;
          $display("FAIL write_data: addr=%0d data=%h, required addr=%0d data=%h",
                   mem_addr, mem_wdata, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm,
                      input bit expect_write, input logic [31:0] word);
    int t;
    t = 0;
    while (in_ready !== 1'b1 && t < 20) begin
      tick(1);
      t++;
    end
    if (t >= 20) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready=%b, required 1 within 20 cycles", in_ready);
      return;
    end
    in_valid = 1'b1;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    if (expect_write) begin
      sb.push_back({exp_ptr, word});
      exp_ptr++;
    end
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    exp_ptr = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    tick(2);
    n_cmp++;
    if ({mem_we, mem_addr, mem_wdata, count, full, err, in_ready} !==
        {1'b0, 2'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_state: we=%b addr=%0d wdata=%h count=%0d full=%b err=%b rdy=%b, required 0 0 0 0 0 0 1",
               mem_we, mem_addr, mem_wdata, count, full, err, in_ready);
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_addi();
    send(6'd10, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093);
    tick(1);
    n_cmp++;
    if ({count, in_ready, mem_we, mem_addr, mem_wdata} !== {3'd1, 1'b1, 1'b0, 2'd0, 32'h00500093}) begin
      n_bad++;
      $display("FAIL addi_after: count=%0d rdy=%b we=%b addr=%0d wdata=%h, required 1 1 0 0 00500093",
               count, in_ready, mem_we, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_r_type();
    send(6'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
    send(6'd1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h402081B3);
    tick(1);
    n_cmp++;
    if (count !== 3'd3) begin
      n_bad++;
      $display("FAIL r_type_count: count=%0d, required 3", count);
    end
    do_clear();
  endtask

  task automatic test_encodings_full();
    send(6'd22, 5'd0, 5'd1, 5'd2, 32'd8,        1'b1, 32'h0020A423);
    send(6'd23, 5'd0, 5'd1, 5'd2, 32'd8,        1'b1, 32'h00208463);
    send(6'd29, 5'd1, 5'd0, 5'd0, 32'd16,       1'b1, 32'h010000EF);
    send(6'd31, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, 32'h123452B7);
    tick(1);
    n_cmp++;
    if ({full, in_ready, count} !== {1'b1, 1'b0, 3'd4}) begin
      n_bad++;
      $display("FAIL full_state: full=%b rdy=%b count=%0d, required 1 0 4", full, in_ready, count);
    end
    // A fifth command is held valid but must never be accepted.
    in_valid = 1'b1; in_op = 6'd10; in_rd = 5'd1; in_rs1 = 5'd0; in_imm = 32'd1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      n_cmp++;
      if ({in_ready, count} !== {1'b0, 3'd4}) begin
        n_bad++;
        $display("FAIL fifth_cmd: rdy=%b count=%0d, required 0 4", in_ready, count);
      end
    end
    in_valid = 1'b0;
    do_clear();
    send(6'd16, 5'd1, 5'd1, 5'd0, 32'd3,         1'b1, 32'h4030D093);
    send(6'd20, 5'd2, 5'd3, 5'd0, -32'sd4,       1'b1, 32'hFFC1A103);
    send(6'd32, 5'd1, 5'd0, 5'd0, 32'h00001000,  1'b1, 32'h00001097);
    tick(1);
    n_cmp++;
    if ({count, full} !== {3'd3, 1'b0}) begin
      n_bad++;
      $display("FAIL enc2_count: count=%0d full=%b, required 3 0", count, full);
    end
    do_clear();
  endtask

  task automatic test_boundary();
    send(6'd10, 5'd1, 5'd0, 5'd0, -32'sd2048, 1'b1, 32'h80000093);
    send(6'd23, 5'd0, 5'd1, 5'd2, -32'sd4096, 1'b1, 32'h80208063);
    send(6'd23, 5'd0, 5'd1, 5'd2, 32'd4094,   1'b1, 32'h7E208FE3);
    tick(1);
    n_cmp++;
    if ({count, err} !== {3'd3, 1'b0}) begin
      n_bad++;
      $display("FAIL boundary_legal: count=%0d err=%b, required 3 0", count, err);
    end
    do_clear();
  endtask

  task automatic test_illegal();
    logic [5:0]  ops  [6] = '{6'd10, 6'd23, 6'd40, 6'd14, 6'd31, 6'd29};
    logic [31:0] imms [6] = '{32'd2048, 32'd3, 32'd0, 32'd32, 32'h12345001, 32'd1048576};
    for (int i = 0; i < 6; i++) begin
      send(ops[i], 5'd1, 5'd1, 5'd2, imms[i], 1'b0, 32'd0);
      tick(1);
      n_cmp++;
      if ({err, in_ready, count} !== {1'b1, 1'b0, 3'd0}) begin
        n_bad++;
        $display("FAIL illegal_%0d: err=%b rdy=%b count=%0d, required 1 0 0", i, err, in_ready, count);
      end
      do_clear();
      n_cmp++;
      if ({err, in_ready, count} !== {1'b0, 1'b1, 3'd0}) begin
        n_bad++;
        $display("FAIL clear_%0d: err=%b rdy=%b count=%0d, required 0 1 0", i, err, in_ready, count);
      end
    end
  endtask

  task automatic test_rst_in_write();
    send(6'd10, 5'd1, 5'd0, 5'd0, 32'd7, 1'b1, 32'h00700093);
    tick(1);
    send(6'd10, 5'd2, 5'd0, 5'd0, 32'd9, 1'b0, 32'd0);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_cancel_we: we=%b, required 0", mem_we);
    end
    tick(1);
    rst = 1'b0;
    exp_ptr = '0;
    n_cmp++;
    if ({count, in_ready, mem_addr, err} !== {3'd0, 1'b1, 2'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL rst_in_write: count=%0d rdy=%b addr=%0d err=%b, required 0 1 0 0",
               count, in_ready, mem_addr, err);
    end
    tick(2);
  endtask

  initial begin
    test_reset();
    test_addi();
    test_r_type();
    test_encodings_full();
    test_boundary();
    test_illegal();
    test_rst_in_write();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL missing_writes: %0d outstanding, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
